// File: rtl/enc_bundler_if.sv
// enc_bundler_if: beat-input and query-output handshake bundle for enc_bundler.
//   in_valid / in_ready / shifted_hv : one lane vector of bound HVs per beat
//   query_hv / out_valid / out_ready : thresholded sample HV to the classifier
//   hv_popcount                      : ones in query_hv (only with ENC_BUNDLER_POPCNT_EN)
// Modports: master = producer/consumer side (binder pack + classifier), slave = bundler.
interface enc_bundler_if #(
  parameter int HV_DIM = 1024,
  parameter int LANES  = 16
) ();
  localparam int POPCNT_W = $clog2(HV_DIM + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic [0:LANES-1][HV_DIM-1:0]  shifted_hv;
  logic [HV_DIM-1:0]             query_hv;
  logic                          out_valid;
  logic                          out_ready;
`ifdef ENC_BUNDLER_POPCNT_EN
  logic [POPCNT_W-1:0]           hv_popcount;

  modport master (output in_valid, shifted_hv, out_ready,
                  input  in_ready, query_hv, out_valid, hv_popcount);
  modport slave  (input  in_valid, shifted_hv, out_ready,
                  output in_ready, query_hv, out_valid, hv_popcount);
`else
  modport master (output in_valid, shifted_hv, out_ready,
                  input  in_ready, query_hv, out_valid);
  modport slave  (input  in_valid, shifted_hv, out_ready,
                  output in_ready, query_hv, out_valid);
`endif
endinterface

// File: rtl/enc_bundler.sv
// enc_bundler: accumulates BEATS lane vectors of bound HVs into per-bit
// saturating counters, thresholds them into a query HV and hands it to the
// classifier over a valid/ready handshake.
//
// Ports:
//   clk            in   rising-edge clock
//   nrst           in   asynchronous reset, active HIGH despite the name
//   start_encoding in   single-cycle pulse, starts a sample (honoured in IDLE only)
//   busy           out  high whenever the FSM is not IDLE
//   bus            slave modport of enc_bundler_if (beat input, query output)
//
// Optional feature: define ENC_BUNDLER_POPCNT_EN to add bus.hv_popcount,
// the number of ones in query_hv, registered together with query_hv.
//
// state    | meaning
// S_IDLE   | waiting for start_encoding; counters cleared on the pulse
// S_ACCUM  | in_ready=1, each accepted beat adds lane popcounts per bit
// S_THRESH | one cycle: register query_hv = (cnt >= THRESHOLD)
// S_OUT    | out_valid=1, query_hv held until out_ready
module enc_bundler #(
  parameter int HV_DIM    = 1024,
  parameter int LANES     = 16,
  parameter int BEATS     = 4,
  parameter int THRESHOLD = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start_encoding,
  output logic         busy,
  enc_bundler_if.slave bus
);
  localparam int CNT_W    = $clog2(LANES*BEATS + 1);
  localparam int SUM_W    = $clog2(LANES + 1);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int POPCNT_W = $clog2(HV_DIM + 1);

  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(LANES*BEATS);
  localparam logic [CNT_W-1:0]  CNT_THR   = CNT_W'(THRESHOLD);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS-1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_THRESH, S_OUT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BEAT_W-1:0]  r_beat;
  logic [CNT_W-1:0]   r_cnt     [HV_DIM];
  logic [CNT_W-1:0]   w_cnt_nxt [HV_DIM];
  logic [HV_DIM-1:0]  w_thr;
  logic [HV_DIM-1:0]  r_query;
  logic               w_accept;
  logic               w_clear;

  assign w_accept = (r_state == S_ACCUM) && bus.in_valid;
  assign w_clear  = (r_state == S_IDLE) && start_encoding;

  // Per-bit adder: popcount of this bit over all lanes, added to the counter
  // with one spare bit so the saturation compare cannot wrap.
  for (genvar gb = 0; gb < HV_DIM; gb++) begin : g_bit
    logic [SUM_W-1:0] w_pop;
    logic [CNT_W:0]   w_sum;

    always_comb begin
      w_pop = '0;
      for (int l = 0; l < LANES; l++) begin
        w_pop = w_pop + SUM_W'(bus.shifted_hv[l][gb]);
      end
    end

    assign w_sum          = {1'b0, r_cnt[gb]} + (CNT_W+1)'(w_pop);
    assign w_cnt_nxt[gb]  = (w_sum > {1'b0, CNT_SAT}) ? CNT_SAT : w_sum[CNT_W-1:0];
    assign w_thr[gb]      = (r_cnt[gb] >= CNT_THR);
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start_encoding) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (w_accept && (r_beat == LAST_BEAT)) w_state_nxt = S_THRESH;
      S_THRESH: w_state_nxt = S_OUT;
      S_OUT:    if (bus.out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_ACCUM);
    bus.out_valid = (r_state == S_OUT);
    busy          = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_beat  <= '0;
      r_query <= '0;
      for (int b = 0; b < HV_DIM; b++) r_cnt[b] <= '0;
    end else begin
      if (w_clear) begin
        r_beat <= '0;
        for (int b = 0; b < HV_DIM; b++) r_cnt[b] <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + BEAT_W'(1);
        for (int b = 0; b < HV_DIM; b++) r_cnt[b] <= w_cnt_nxt[b];
      end
      if (r_state == S_THRESH) r_query <= w_thr;
    end
  end

  assign bus.query_hv = r_query;

`ifdef ENC_BUNDLER_POPCNT_EN
  logic [POPCNT_W-1:0] w_popcnt;
  logic [POPCNT_W-1:0] r_popcnt;

  always_comb begin
    w_popcnt = '0;
    for (int b = 0; b < HV_DIM; b++) w_popcnt = w_popcnt + POPCNT_W'(w_thr[b]);
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_popcnt <= '0;
    end else if (r_state == S_THRESH) begin
      r_popcnt <= w_popcnt;
    end
  end

  assign bus.hv_popcount = r_popcnt;
`endif
endmodule
